// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID/EX pipeline register with valid/ready handshake, flush bubble and stall counter
// Optional 1-entry skid buffer (registered id_ready) when ID_EX_SKID_EN is defined.
module id_ex_pipe_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int WB_W        = 2,
    parameter int M_W         = 3,
    parameter int ALU_OP_W    = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   startin,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [WB_W-1:0]        id_wb,
    input  logic [M_W-1:0]         id_m,
    input  logic [ALU_OP_W+1:0]    id_ex,
    input  logic [DATA_W-1:0]      id_pc_plus_4,
    input  logic [DATA_W-1:0]      id_reg_data1,
    input  logic [DATA_W-1:0]      id_reg_data2,
    input  logic [DATA_W-1:0]      id_sign_ext_imm,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic [REG_AW-1:0]      id_rd,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [WB_W-1:0]        ex_wb,
    output logic [M_W-1:0]         ex_m,
    output logic                   ex_reg_dst,
    output logic [ALU_OP_W-1:0]    ex_alu_op,
    output logic                   ex_alu_src,
    output logic [DATA_W-1:0]      ex_pc_plus_4,
    output logic [DATA_W-1:0]      ex_reg_data1,
    output logic [DATA_W-1:0]      ex_reg_data2,
    output logic [DATA_W-1:0]      ex_sign_ext_imm,
    output logic [REG_AW-1:0]      ex_rs,
    output logic [REG_AW-1:0]      ex_rt,
    output logic [REG_AW-1:0]      ex_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int EX_W  = ALU_OP_W + 2;
    localparam int ENT_W = WB_W + M_W + EX_W + 4 * DATA_W + 3 * REG_AW;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] out_ent;
    logic             advance;
    logic             accept;

    // The EX group packs as {alu_src, alu_op, reg_dst}, so it unpacks positionally.
    assign in_ent = {id_wb, id_m, id_ex, id_pc_plus_4, id_reg_data1, id_reg_data2,
                     id_sign_ext_imm, id_rs, id_rt, id_rd};
    assign {ex_wb, ex_m, ex_alu_src, ex_alu_op, ex_reg_dst, ex_pc_plus_4, ex_reg_data1,
            ex_reg_data2, ex_sign_ext_imm, ex_rs, ex_rt, ex_rd} = out_ent;

    assign advance = !ex_valid || ex_ready;
    assign accept  = id_valid && id_ready;

`ifdef ID_EX_SKID_EN
    logic             skid_valid;
    logic [ENT_W-1:0] skid_ent;

    assign id_ready = !skid_valid;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            ex_valid   <= 1'b0;
            out_ent    <= '0;
            skid_valid <= 1'b0;
            skid_ent   <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            out_ent    <= '0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            // A full skid blocks accept, so it drains first and order is kept.
            if (skid_valid) begin
                out_ent    <= skid_ent;
                ex_valid   <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_ent  <= accept ? in_ent : '0;
                ex_valid <= accept;
            end
        end else if (accept) begin
            skid_ent   <= in_ent;
            skid_valid <= 1'b1;
        end
    end
`else
    assign id_ready = advance;

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            ex_valid <= 1'b0;
            out_ent  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            out_ent  <= '0;
        end else if (advance) begin
            // Bubbles are stored as all-zero so ex_* read 0 whenever ex_valid is low.
            out_ent  <= accept ? in_ent : '0;
            ex_valid <= accept;
        end
    end
`endif

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            stall_cnt <= '0;
        end else if (ex_valid && !ex_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_ONE;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb/tb_id_ex_pipe_stage.sv - scoreboard bench for id_ex_pipe_stage (directed + random, either ID_EX_SKID_EN build)
module tb_id_ex_pipe_stage;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int SW = 4;
    localparam int SAT = 15;

    typedef struct packed {
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [DW-1:0] pc;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } ent_t;

    logic          clk = 1'b0;
    logic          startin = 1'b1;
    logic          flush = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [1:0]    id_wb = '0;
    logic [2:0]    id_m = '0;
    logic [3:0]    id_ex = '0;
    logic [DW-1:0] id_pc_plus_4 = '0, id_reg_data1 = '0, id_reg_data2 = '0, id_sign_ext_imm = '0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          ex_valid;
    logic          ex_ready = 1'b0;
    logic [1:0]    ex_wb;
    logic [2:0]    ex_m;
    logic          ex_reg_dst;
    logic [1:0]    ex_alu_op;
    logic          ex_alu_src;
    logic [DW-1:0] ex_pc_plus_4, ex_reg_data1, ex_reg_data2, ex_sign_ext_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [SW-1:0] stall_cnt;

    int   total = 0;
    int   bad = 0;
    ent_t q[$];
    bit   mon_en = 1'b0;
    bit   acc_flag = 1'b0;
    int   exp_stall = 0;

    id_ex_pipe_stage #(
        .DATA_W(DW), .REG_AW(AW), .WB_W(2), .M_W(3), .ALU_OP_W(2), .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .startin(startin), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
        .id_pc_plus_4(id_pc_plus_4), .id_reg_data1(id_reg_data1),
        .id_reg_data2(id_reg_data2), .id_sign_ext_imm(id_sign_ext_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_reg_data1(ex_reg_data1),
        .ex_reg_data2(ex_reg_data2), .ex_sign_ext_imm(ex_sign_ext_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t cur_in();
        ent_t e;
        e = '{wb: id_wb, m: id_m, ex: id_ex, pc: id_pc_plus_4, d1: id_reg_data1,
              d2: id_reg_data2, imm: id_sign_ext_imm, rs: id_rs, rt: id_rt, rd: id_rd};
        return e;
    endfunction

    function automatic ent_t cur_out();
        ent_t e;
        e = '{wb: ex_wb, m: ex_m, ex: {ex_alu_src, ex_alu_op, ex_reg_dst}, pc: ex_pc_plus_4,
              d1: ex_reg_data1, d2: ex_reg_data2, imm: ex_sign_ext_imm,
              rs: ex_rs, rt: ex_rt, rd: ex_rd};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ent(input string nm, input ent_t act, input ent_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_entry(input logic [3:0] ex);
        id_wb           = 2'($urandom);
        id_m            = 3'($urandom);
        id_ex           = ex;
        id_pc_plus_4    = {$urandom, $urandom};
        id_reg_data1    = {$urandom, $urandom};
        id_reg_data2    = {$urandom, $urandom};
        id_sign_ext_imm = {$urandom, $urandom};
        id_rs           = 6'($urandom);
        id_rt           = 6'($urandom);
        id_rd           = 6'($urandom);
    endtask

    // Stimulus side of the scoreboard: record every accepted, non-flushed entry.
    always @(negedge clk) begin
        #1;
        acc_flag = id_valid && id_ready && !flush && startin;
        if (mon_en && acc_flag) q.push_back(cur_in());
    end

    // Monitor: the stage holds exactly the accepted-but-unconsumed entries, oldest on ex_*.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_valid;
            exp_valid = (q.size() > 0);
            chk("ex_valid", ex_valid, exp_valid);
`ifdef ID_EX_SKID_EN
            chk("id_ready", id_ready, q.size() < 2);
`else
            chk("id_ready", id_ready, !exp_valid || ex_ready);
`endif
            chk("stall_cnt", stall_cnt, exp_stall);
            if (!ex_valid) begin
                chk_ent("bubble_zero", cur_out(), '0);
            end else if (q.size() == 0) begin
                chk("unexpected_entry", 1, 0);
            end else begin
                chk_ent("ex_entry", cur_out(), q[0]);
                if (ex_ready && !flush) void'(q.pop_front());
            end
            if (flush) q.delete();
            if (exp_valid && !ex_ready && exp_stall < SAT) exp_stall++;
        end
    end

    initial begin
        logic [DW-1:0] pc0;
        #1 startin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk_ent("rst_outputs", cur_out(), '0);
        startin = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
        chk("rst_id_ready", id_ready, 1);

        // Stream of four entries with EX group 4'b1011.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            id_valid = 1'b1; ex_ready = 1'b1; set_entry(4'b1011);
            @(negedge clk);
            if (i == 0) chk("lat_not_yet", ex_valid, 0);
            if (i == 1) begin
                chk("lat_valid", ex_valid, 1);
                chk("reg_dst", ex_reg_dst, 1);
                chk("alu_op", ex_alu_op, 2'b01);
                chk("alu_src", ex_alu_src, 1);
            end
        end

        // Stall with a further entry offered.
        @(posedge clk); #1;
        set_entry(4'($urandom)); id_valid = 1'b1; ex_ready = 1'b0;
        @(negedge clk);
        pc0 = ex_pc_plus_4;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall5_cnt", stall_cnt, 5);
        chk("stall5_frozen", ex_pc_plus_4, pc0);
        chk("stall5_id_ready", id_ready, 0);

        // Flush while stalled (skid full in the skid build) with a new entry offered.
        @(posedge clk); #1;
        flush = 1'b1; set_entry(4'($urandom)); id_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", ex_valid, 0);
        chk_ent("flush_zero", cur_out(), '0);
        chk("flush_id_ready", id_ready, 1);
        chk("flush_keeps_stall", stall_cnt, 7);

        // Saturation of the 4-bit stall counter.
        @(posedge clk); #1;
        set_entry(4'($urandom)); id_valid = 1'b1; ex_ready = 1'b0;
        @(posedge clk); #1;
        id_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_sat", stall_cnt, SAT);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 3; i++) begin
            set_entry(4'($urandom)); id_valid = 1'b1; ex_ready = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        mon_en = 1'b0; startin = 1'b0;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk_ent("arst_zero", cur_out(), '0);
        chk("arst_stall", stall_cnt, 0);
        q.delete(); exp_stall = 0; id_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        startin = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        chk("arst_id_ready", id_ready, 1);
        chk("arst_stall_rel", stall_cnt, 0);

        // Random valid/ready/flush traffic; decode holds an unaccepted entry.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            if (!(id_valid && !acc_flag && !flush)) begin
                id_valid = ($urandom_range(3) != 0);
                set_entry(4'($urandom));
            end
            ex_ready = ($urandom_range(2) != 0);
            flush    = ($urandom_range(39) == 0);
        end

        @(posedge clk); #1;
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", ex_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
